pht_predictor: RTL and testbench
================================

// Module: pht_predictor
// PURPOSE
//  Pattern history table: the consumer of the per-branch history record.
//  Fetch presents the branch pc index and its history. The block forms a
//  gshare index, returns a taken/not-taken prediction from 2-bit saturating
//  counters, and queues the lookup in an in-flight FIFO. When EX resolves
//  the branch (in order), the oldest entry is popped, its counter is trained
//  and mispredict is flagged. flush discards all younger in-flight lookups.
// PARAMETERS
//  IWIDTH  6  width of pc-derived branch index
//  HWIDTH  6  history width; PHT has 2**HWIDTH counters
//  DEPTH   4  in-flight FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-low reset
//  en             in   1       global enable; 0 = stall, no state changes
//  lookup_valid   in   1       fetch presents a branch this cycle
//  pc_index       in   IWIDTH  index hashed from branch instr address
//  history        in   HWIDTH  history record for this branch
//  lookup_ready   out  1       FIFO can accept a lookup (=!full)
//  predict_taken  out  1       prediction for current lookup (comb.)
//  resolve_valid  in   1       oldest in-flight branch resolved this cycle
//  resolve_taken  in   1       actual outcome of that branch
//  flush          in   1       discard all in-flight entries
//  mispredict     out  1       resolved outcome != stored prediction (comb.)
//  inflight       out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - reset low: all counters := 2'b01 (weakly not-taken); FIFO empty,
//    rd/wr ptrs 0, inflight 0, lookup_ready 1, mispredict 0. Async assert,
//    state held while low; mid-operation reset drops all in-flight entries.
//  - pidx = history ^ pc_index mapped to HWIDTH bits: truncate if
//    IWIDTH>HWIDTH, zero-extend if IWIDTH<HWIDTH.
//  - predict_taken = pht[pidx][1], combinational, same cycle as lookup.
//    The value is read pre-update. No bypass from a same-cycle write.
//  - push = en & lookup_valid & lookup_ready: the FIFO stores {pidx,
//    predict_taken} at wr_ptr, and wr_ptr wraps mod DEPTH.
//  - lookup_ready = (inflight != DEPTH). Deliberately ignores a same-cycle
//    pop (no pass-through when full).
//  - pop = en & resolve_valid & (inflight != 0): head counter is updated
//    saturating. Taken: 11 stays 11, else +1. Not-taken: 00 stays 00,
//    else -1. rd_ptr wraps mod DEPTH.
//  - mispredict = pop & (resolve_taken != head.pred); zero in all other
//    cases.
//  - resolve_valid with empty FIFO: ignored, with no update and
//    mispredict 0.
//  - push & pop same cycle: inflight unchanged; both pointers advance.
//  - flush (requires en): the same-cycle pop/training still happens first.
//    Then the FIFO is emptied (inflight 0, rd_ptr := wr_ptr), and any
//    same-cycle push is dropped.
//  - Different-index write and lookup in the same cycle are independent.
//    Same-index: the lookup sees the old value, and the new value is
//    visible next cycle.
//  - en=0: no counter, pointer or occupancy change; predict_taken and
//    lookup_ready still driven; mispredict 0.
// TESTING
//  1. Release reset, lookup pc=0x05, hist=0x00 -> predict_taken 0,
//     inflight 1.
//  2. Resolve taken 3x on pidx 0x05 -> counter 01,10,11,11. Next lookup
//     predicts 1. Mispredict on 1st resolve only (stored pred was 0).
//  3. Push 4 lookups with no resolve -> lookup_ready 0 and 5th push
//     ignored. Push+resolve same cycle while full -> push dropped,
//     inflight 3.
//  4. Lookup pidx 0x12 while resolving head pidx 0x12 with taken from
//     01 -> predict 0 this cycle, 1 next cycle.
//  5. 3 in flight, resolve mispredict + flush same cycle -> head trained,
//     inflight 0. Resolve with empty FIFO -> no change, mispredict 0.
//  6. en=0 with lookup/resolve asserted -> no state change. Assert reset
//     with 2 in flight -> inflight 0, all counters 01 immediately.

Source files
------------

// File: rtl/pht_predictor.sv
// Gshare pattern history table with 2-bit saturating counters and an in-order
// in-flight FIFO that carries {index, prediction} from fetch to branch resolution.
module pht_predictor #(
  parameter int IWIDTH = 6,
  parameter int HWIDTH = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     lookup_valid,
  input  logic [IWIDTH-1:0]        pc_index,
  input  logic [HWIDTH-1:0]        history,
  output logic                     lookup_ready,
  output logic                     predict_taken,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic                     flush,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   inflight
);

  localparam int PW       = $clog2(DEPTH);
  localparam int PHT_SIZE = 2 ** HWIDTH;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  logic [1:0]        pht_reg [PHT_SIZE];
  logic [HWIDTH-1:0] fifo_idx_reg [DEPTH];
  logic              fifo_pred_reg [DEPTH];
  logic [PW-1:0]     rd_ptr_reg;
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW:0]       count_reg;

  logic [HWIDTH-1:0] pc_fold;
  logic [HWIDTH-1:0] pidx;
  logic [HWIDTH-1:0] head_idx;
  logic              head_pred;
  logic [1:0]        head_ctr;
  logic [1:0]        ctr_next;
  logic              push;
  logic              push_commit;
  logic              pop;
  logic              flush_act;

  // Fit the pc index to the table width before hashing with history.
  generate
    if (IWIDTH >= HWIDTH) begin : g_trunc
      assign pc_fold = pc_index[HWIDTH-1:0];
    end else begin : g_zext
      assign pc_fold = {{(HWIDTH - IWIDTH){1'b0}}, pc_index};
    end
  endgenerate

  assign pidx          = history ^ pc_fold;
  assign predict_taken = pht_reg[pidx][1];
  assign lookup_ready  = (count_reg != FULL_COUNT);
  assign inflight      = count_reg;

  assign head_idx  = fifo_idx_reg[rd_ptr_reg];
  assign head_pred = fifo_pred_reg[rd_ptr_reg];
  assign head_ctr  = pht_reg[head_idx];

  assign flush_act   = en & flush;
  assign push        = en & lookup_valid & lookup_ready;
  assign push_commit = push & ~flush_act;
  assign pop         = en & resolve_valid & (count_reg != '0);
  assign mispredict  = pop & (resolve_taken != head_pred);

  always_comb begin
    ctr_next = head_ctr;
    if (resolve_taken) begin
      if (head_ctr != 2'b11) ctr_next = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) ctr_next = head_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_reg[i] <= 2'b01;
    end else if (pop) begin
      pht_reg[head_idx] <= ctr_next;
    end
  end

  // Payload needs no reset: entries are only read while counted as in flight.
  always_ff @(posedge clk) begin
    if (push_commit) begin
      fifo_idx_reg[wr_ptr_reg]  <= pidx;
      fifo_pred_reg[wr_ptr_reg] <= predict_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_act) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push_commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)         rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_commit, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_pht_predictor.sv
// Directed vector bench for pht_predictor: table of per-cycle stimulus with
// expected pre-edge outputs, plus a hand-written mid-operation reset sequence.
module tb_pht_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       lookup_valid;
  logic [5:0] pc_index;
  logic [5:0] history;
  logic       lookup_ready;
  logic       predict_taken;
  logic       resolve_valid;
  logic       resolve_taken;
  logic       flush;
  logic       mispredict;
  logic [2:0] inflight;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pht_predictor #(.IWIDTH(6), .HWIDTH(6), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .lookup_valid(lookup_valid),
    .pc_index(pc_index), .history(history), .lookup_ready(lookup_ready),
    .predict_taken(predict_taken), .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken), .flush(flush), .mispredict(mispredict),
    .inflight(inflight)
  );

  typedef struct {
    logic       en, lv;
    logic [5:0] pc, hist;
    logic       rv, rt, fl;
    logic       pred, rdy, misp;
    logic [2:0] infl;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  function automatic vec_t mk(logic e, logic lv, logic [5:0] pc, logic [5:0] h,
                              logic rv, logic rt, logic fl,
                              logic pred, logic rdy, logic misp, logic [2:0] infl);
    vec_t v;
    v.en = e; v.lv = lv; v.pc = pc; v.hist = h; v.rv = rv; v.rt = rt; v.fl = fl;
    v.pred = pred; v.rdy = rdy; v.misp = misp; v.infl = infl;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and check outputs before the committing edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(posedge clk);
    #1;
    en = v.en; lookup_valid = v.lv; pc_index = v.pc; history = v.hist;
    resolve_valid = v.rv; resolve_taken = v.rt; flush = v.fl;
    #3;
    $display("%s[%0d] en=%0b lv=%0b pc=%02h h=%02h rv=%0b rt=%0b fl=%0b -> pred=%0b rdy=%0b misp=%0b infl=%0d",
             tag, idx, v.en, v.lv, v.pc, v.hist, v.rv, v.rt, v.fl,
             predict_taken, lookup_ready, mispredict, inflight);
    check($sformatf("%s[%0d] predict_taken", tag, idx), {7'd0, predict_taken}, {7'd0, v.pred});
    check($sformatf("%s[%0d] lookup_ready", tag, idx), {7'd0, lookup_ready}, {7'd0, v.rdy});
    check($sformatf("%s[%0d] mispredict", tag, idx), {7'd0, mispredict}, {7'd0, v.misp});
    check($sformatf("%s[%0d] inflight", tag, idx), {5'd0, inflight}, {5'd0, v.infl});
  endtask

  initial begin
    //           en lv pc     hist   rv rt fl pred rdy misp infl
    // counter on pidx 05: train up, saturate, train down, saturate
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 1, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 1, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h00, 6'h05, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 1, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h05, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 1, 3'd1));
    // fill to full, blocked push, push+pop while full, drain
    tbl1.push_back(mk(1, 1, 6'h01, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h02, 6'h00, 0, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h03, 6'h00, 0, 0, 0, 0, 1, 0, 3'd2));
    tbl1.push_back(mk(1, 1, 6'h04, 6'h00, 0, 0, 0, 0, 1, 0, 3'd3));
    tbl1.push_back(mk(1, 1, 6'h06, 6'h00, 0, 0, 0, 0, 0, 0, 3'd4));
    tbl1.push_back(mk(1, 1, 6'h06, 6'h00, 1, 1, 0, 0, 0, 1, 3'd4));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd3));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd2));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h01, 6'h00, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 1, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h02, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd1));
    // same-index lookup and training in one cycle (pidx 0x12 = 0x30^0x22)
    tbl1.push_back(mk(1, 1, 6'h30, 6'h22, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h12, 6'h00, 1, 1, 0, 0, 1, 1, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h12, 6'h00, 0, 0, 0, 1, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 1, 3'd2));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd1));
    // flush with a mispredicting resolve and a push in the same cycle
    tbl1.push_back(mk(1, 1, 6'h20, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h21, 6'h00, 0, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h22, 6'h00, 0, 0, 0, 0, 1, 0, 3'd2));
    tbl1.push_back(mk(1, 1, 6'h23, 6'h00, 1, 1, 1, 0, 1, 1, 3'd3));
    tbl1.push_back(mk(1, 1, 6'h20, 6'h00, 0, 0, 0, 1, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd0));
    // stall: nothing may move while en is low
    tbl1.push_back(mk(1, 1, 6'h21, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(0, 1, 6'h20, 6'h00, 1, 0, 0, 1, 1, 0, 3'd1));
    tbl1.push_back(mk(0, 1, 6'h21, 6'h00, 1, 1, 1, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1, 0, 3'd1));
    tbl1.push_back(mk(1, 1, 6'h21, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl1.push_back(mk(1, 1, 6'h22, 6'h00, 0, 0, 0, 0, 1, 0, 3'd1));
    // after the mid-operation reset: counters back to 01, FIFO empty
    tbl2.push_back(mk(1, 1, 6'h12, 6'h00, 0, 0, 0, 0, 1, 0, 3'd0));
    tbl2.push_back(mk(1, 1, 6'h20, 6'h00, 0, 0, 0, 0, 1, 0, 3'd1));
    tbl2.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 1, 3'd2));
    tbl2.push_back(mk(1, 1, 6'h12, 6'h00, 1, 1, 0, 1, 1, 1, 3'd1));
    tbl2.push_back(mk(1, 0, 6'h00, 6'h00, 1, 1, 0, 0, 1, 0, 3'd1));

    en = 1'b1; lookup_valid = 1'b0; pc_index = '0; history = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; flush = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("reset: pred=%0b rdy=%0b misp=%0b infl=%0d", predict_taken, lookup_ready, mispredict, inflight);
    check("reset inflight", {5'd0, inflight}, 8'd0);
    check("reset lookup_ready", {7'd0, lookup_ready}, 8'd1);
    check("reset mispredict", {7'd0, mispredict}, 8'd0);
    check("reset predict_taken", {7'd0, predict_taken}, 8'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i], "t1", i);

    // Reset asserted between edges with two lookups in flight.
    @(posedge clk);
    #1;
    lookup_valid = 1'b0; resolve_valid = 1'b0; flush = 1'b0; en = 1'b1;
    pc_index = 6'h20; history = 6'h00;
    #1;
    check("pre-reset inflight", {5'd0, inflight}, 8'd2);
    check("pre-reset predict_taken", {7'd0, predict_taken}, 8'd1);
    reset = 1'b0;
    #1;
    $display("midreset: pred=%0b rdy=%0b misp=%0b infl=%0d", predict_taken, lookup_ready, mispredict, inflight);
    check("midreset inflight", {5'd0, inflight}, 8'd0);
    check("midreset lookup_ready", {7'd0, lookup_ready}, 8'd1);
    check("midreset predict_taken", {7'd0, predict_taken}, 8'd0);
    lookup_valid = 1'b1; resolve_valid = 1'b1; resolve_taken = 1'b1;
    #1;
    check("midreset mispredict", {7'd0, mispredict}, 8'd0);
    @(posedge clk);
    #1;
    $display("held reset: misp=%0b infl=%0d", mispredict, inflight);
    check("held reset inflight", {5'd0, inflight}, 8'd0);
    check("held reset predict_taken", {7'd0, predict_taken}, 8'd0);
    lookup_valid = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i], "t2", i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
